// File: rtl/macc_seq_if.sv
// Partial-in / result-out valid/ready bundle for macc_seq.
// slave: sequencer side; master: upstream producer and downstream consumer.
interface macc_seq_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );
endinterface

// File: rtl/macc_seq.sv
// Clear/add/hold/present sequencer for the FP16 accumulator array.
// Optional stall watchdog: define MACC_SEQ_TIMEOUT_EN.
module macc_seq #(
  parameter int MaxK          = 256,
  parameter int KW            = $clog2(MaxK + 1),
  parameter int TileCntW      = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                abort,
  macc_seq_if.slave           hs,
  output logic                acc_clear,
  output logic                acc_add_en,
  output logic                busy,
  output logic [KW-1:0]       beat_cnt,
  output logic [TileCntW-1:0] tile_cnt,
  output logic                err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [KW-1:0] KMax = KW'(MaxK);

  state_t        state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_eff;
  logic          beat;
  logic          last;
  logic          stall_hit;

  assign k_eff = (k_len > KMax) ? KMax : k_len;
  assign beat  = (state == ACCUM) && hs.in_valid;
  assign last  = (beat_cnt == k_q - KW'(1));

  assign acc_clear    = (state == IDLE);
  assign acc_add_en   = beat;
  assign hs.in_ready  = (state == ACCUM);
  assign hs.out_valid = (state == OUT);
  assign busy         = (state != IDLE);

`ifdef MACC_SEQ_TIMEOUT_EN
  localparam int SW = $clog2(TimeoutCycles + 1);
  localparam logic [SW-1:0] StallLim = SW'(TimeoutCycles - 1);

  logic [SW-1:0] stall_q;

  assign stall_hit = (state == ACCUM) && !beat &&
                     (stall_q == StallLim);

  // Count consecutive idle ACCUM cycles; any beat or exit restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= stall_hit && !abort;
      if (state != ACCUM || beat || abort || stall_hit)
        stall_q <= '0;
      else
        stall_q <= stall_q + SW'(1);
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Tile sequencing: abort beats handshakes, last beat goes to OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_q      <= '0;
      beat_cnt <= '0;
      tile_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            beat_cnt <= '0;
            k_q      <= k_eff;
            state    <= (k_eff != '0) ? ACCUM : OUT;
          end
        end
        ACCUM: begin
          if (abort) begin
            state <= IDLE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (last)
              state <= OUT;
          end else if (stall_hit) begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (abort) begin
            state <= IDLE;
          end else if (hs.out_ready) begin
            tile_cnt <= tile_cnt + TileCntW'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_macc_seq.sv
// Bench for macc_seq: random tiles against a sum-of-partials model,
// plus abort, reset, clamp and stalled-output cases.
module tb_macc_seq;
  localparam int KW = 9;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          acc_clear;
  logic          acc_add_en;
  logic          busy;
  logic [KW-1:0] beat_cnt;
  logic [TW-1:0] tile_cnt;
  logic          err_timeout;
  logic [31:0]   addend;
  logic [31:0]   arr;

  int checks = 0;
  int errors = 0;
  int exp_tiles = 0;

  macc_seq_if hs ();

  macc_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .abort       (abort),
    .hs          (hs.slave),
    .acc_clear   (acc_clear),
    .acc_add_en  (acc_add_en),
    .busy        (busy),
    .beat_cnt    (beat_cnt),
    .tile_cnt    (tile_cnt),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Accumulator array stand-in: clear, add addend, or add zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      arr <= '0;
    else if (acc_clear)
      arr <= '0;
    else if (acc_add_en)
      arr <= arr + addend;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full tile: start, random-gap partials, stalled output, handoff.
  task automatic run_tile(input int k, input int pct, input int ostall);
    int kk;
    int acc;
    int cyc;
    logic [31:0] sum;
    logic v;
    kk  = (k > 256) ? 256 : k;
    acc = 0;
    cyc = 0;
    sum = '0;
    @(negedge clk);
    #1;
    chk("idle_clear", acc_clear, 1);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", hs.in_ready, 0);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    while (acc < kk && cyc < 8 * kk + 20) begin
      v = ($urandom_range(99) < pct);
      hs.in_valid = v;
      addend = $urandom_range(1000);
      #1;
      chk("acc_in_ready", hs.in_ready, 1);
      chk("acc_add_en", acc_add_en, v);
      chk("acc_beat_cnt", beat_cnt, acc);
      chk("acc_out_valid", hs.out_valid, 0);
      chk("acc_clear_lo", acc_clear, 0);
      if (v) begin
        acc++;
        sum = sum + addend;
      end
      @(negedge clk);
      cyc++;
    end
    hs.in_valid = 1'b0;
    if (acc < kk)
      chk("accum_budget", acc, kk);
    #1;
    chk("out_valid", hs.out_valid, 1);
    chk("out_in_ready", hs.in_ready, 0);
    chk("out_add_en", acc_add_en, 0);
    chk("out_result", arr, sum);
    chk("out_beat_cnt", beat_cnt, kk);
    hs.out_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < ostall; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", hs.out_valid, 1);
      chk("stall_result", arr, sum);
    end
    start = 1'b0;
    hs.out_ready = 1'b1;
    @(negedge clk);
    hs.out_ready = 1'b0;
    exp_tiles++;
    #1;
    chk("done_busy", busy, 0);
    chk("done_clear", acc_clear, 1);
    chk("done_tiles", tile_cnt, exp_tiles);
    chk("done_out_valid", hs.out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    abort = 1'b0;
    addend = '0;
    hs.in_valid = 1'b0;
    hs.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clear", acc_clear, 1);
    chk("rst_add_en", acc_add_en, 0);
    chk("rst_in_ready", hs.in_ready, 0);
    chk("rst_out_valid", hs.out_valid, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_tiles", tile_cnt, 0);
    chk("rst_err", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_tile(4, 100, 0);
    run_tile(3, 40, 5);
    run_tile(0, 100, 2);
    for (int t = 0; t < 8; t++)
      run_tile($urandom_range(12), 30 + $urandom_range(70),
               $urandom_range(4));

    // abort with a beat pending: abort wins, tile dropped
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(8);
    @(negedge clk);
    start = 1'b0;
    hs.in_valid = 1'b1;
    addend = 32'd77;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_add_en", acc_add_en, 1);
    @(negedge clk);
    abort = 1'b0;
    hs.in_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_clear", acc_clear, 1);
    chk("abort_tiles", tile_cnt, exp_tiles);
    run_tile(1, 100, 0);

    // abort in OUT beats out_ready
    @(negedge clk);
    start = 1'b1;
    k_len = '0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    hs.out_ready = 1'b1;
    #1;
    chk("abort_out_valid", hs.out_valid, 1);
    @(negedge clk);
    abort = 1'b0;
    hs.out_ready = 1'b0;
    #1;
    chk("abort_out_busy", busy, 0);
    chk("abort_out_tiles", tile_cnt, exp_tiles);

    // abort in IDLE suppresses start
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    k_len = KW'(5);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("idle_abort_busy", busy, 0);

    // asynchronous reset in the middle of a tile
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(5);
    @(negedge clk);
    start = 1'b0;
    hs.in_valid = 1'b1;
    @(negedge clk);
    hs.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clear", acc_clear, 1);
    chk("mid_rst_beat", beat_cnt, 0);
    chk("mid_rst_tiles", tile_cnt, 0);
    exp_tiles = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // oversized k_len clamps to 256 partials
    run_tile(300, 100, 0);
    run_tile(2, 100, 1);
    chk("end_err", err_timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end
endmodule
